// File: rtl/sim_checker.sv
// sim_checker -- end-of-simulation result checker for a CPU testbench.
//
// While the CPU runs, the block snoops data-memory writes and counts cycles.
// A write of FLAG_VALUE to FLAG_ADDR ends the run: the block then reads
// a window of data memory through a second read port and compares it word by
// word against a golden ROM. If no flag arrives within TIMEOUT_CYC cycles,
// the run ends with timeout set and no memory is read.
//
// Read ports (rd_* and gold_*) are synchronous with 1-cycle latency. An
// address is presented during cycle t, and its data is valid during cycle t+1.
//
// Ports
//   clk                      single clock, all state on the rising edge
//   rst                      asynchronous, active-low reset
//   mon_enable, mon_write    snooped data-memory strobes
//   mon_address, mon_in      snooped data-memory write address / data
//   rd_enable, rd_address    second data-memory read port (request)
//   rd_data                  second data-memory read port (response)
//   gold_address, gold_data  golden ROM read port, indexed from 0
//   done, pass, timeout      run status
//   err_count, cycle_count   mismatch total / run length in cycles
//   mis_valid, mis_index,    one-cycle report per mismatching word
//   mis_actual, mis_expect
//   state_dbg                current FSM state (RUN=0 LEN=1 SWEEP=2 DRAIN=3 DONE=4)
module sim_checker #(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]  FLAG_ADDR   = 16'hFFFF,
    parameter logic [DATA_W-1:0]  FLAG_VALUE  = 32'hFFFF_F000,
    parameter logic [ADDR_W-1:0]  CHECK_BASE  = '0,
    parameter int                 CHECK_LEN   = 32,
    parameter int                 DYN_LEN     = 0,
    parameter int                 MAX_LEN     = 4096,
    parameter int                 TIMEOUT_CYC = 10000000,
    parameter int                 CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_enable,
    input  logic              mon_write,
    input  logic [ADDR_W-1:0] mon_address,
    input  logic [DATA_W-1:0] mon_in,
    output logic              rd_enable,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] gold_address,
    input  logic [DATA_W-1:0] gold_data,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              mis_valid,
    output logic [ADDR_W-1:0] mis_index,
    output logic [DATA_W-1:0] mis_actual,
    output logic [DATA_W-1:0] mis_expect,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_LEN   = 3'd1,
        S_SWEEP = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W:0]   MAX_N    = (CNT_W+1)'(MAX_LEN);
    localparam logic [CNT_W-1:0] STATIC_N = CNT_W'((CHECK_LEN < MAX_LEN) ? CHECK_LEN : MAX_LEN);

    state_t            state;
    logic              len_wait;   // LEN: 0 = read issued, 1 = length word on rd_data
    logic [CNT_W-1:0]  len_n;      // number of words to sweep
    logic [CNT_W-1:0]  idx;        // next sweep index to issue
    logic              cmp_valid;  // rd_data/gold_data hold a sweep word this cycle
    logic [ADDR_W-1:0] cmp_idx;    // sweep index of that word

    logic              flag_hit;
    logic [CNT_W:0]    dyn_raw;
    logic [CNT_W-1:0]  dyn_n;
    logic              cmp_miss;
    logic              start_now;
    logic [CNT_W-1:0]  start_n;

    assign flag_hit = mon_enable & mon_write & (mon_address == FLAG_ADDR) & (mon_in == FLAG_VALUE);

    // word*2+1 is the word shifted left with a 1 shifted in; one extra bit
    // keeps an all-ones word from wrapping before the clamp.
    assign dyn_raw = {CNT_W'(rd_data), 1'b1};
    assign dyn_n   = (dyn_raw > MAX_N) ? MAX_N[CNT_W-1:0] : dyn_raw[CNT_W-1:0];

    // Written as if/else so that an X or Z on either data input takes the
    // else branch and counts as a mismatch in a 4-state simulator.
    always_comb begin
        cmp_miss = 1'b0;
        if (cmp_valid) begin
            if (rd_data == gold_data) cmp_miss = 1'b0;
            else                      cmp_miss = 1'b1;
        end
    end

    // The sweep starts straight from RUN for a fixed length, or from LEN once
    // the length word has come back.
    always_comb begin
        start_now = 1'b0;
        start_n   = STATIC_N;
        if (state == S_RUN && flag_hit && DYN_LEN == 0) begin
            start_now = 1'b1;
        end
        if (state == S_LEN && len_wait) begin
            start_now = 1'b1;
            start_n   = dyn_n;
        end
    end

    assign pass      = done & ~timeout & (err_count == '0);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_RUN;
            len_wait     <= 1'b0;
            len_n        <= '0;
            idx          <= '0;
            cmp_valid    <= 1'b0;
            cmp_idx      <= '0;
            rd_enable    <= 1'b0;
            rd_address   <= '0;
            gold_address <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            err_count    <= '0;
            cycle_count  <= '0;
            mis_valid    <= 1'b0;
            mis_index    <= '0;
            mis_actual   <= '0;
            mis_expect   <= '0;
        end else begin
            // Compare pipeline: a word issued in cycle t is compared at the
            // end of cycle t+1, whatever state the FSM has moved on to.
            mis_valid <= 1'b0;
            cmp_valid <= rd_enable && (state == S_SWEEP);
            cmp_idx   <= gold_address;
            if (cmp_miss) begin
                mis_valid  <= 1'b1;
                mis_index  <= cmp_idx;
                mis_actual <= rd_data;
                mis_expect <= gold_data;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end

            case (state)
                S_RUN: begin
                    if (flag_hit) begin
                        if (DYN_LEN != 0) begin
                            state      <= S_LEN;
                            len_wait   <= 1'b0;
                            rd_enable  <= 1'b1;
                            rd_address <= CHECK_BASE;
                        end
                    end else if (cycle_count == TO_LAST) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                S_LEN: begin
                    if (!len_wait) begin
                        len_wait  <= 1'b1;
                        rd_enable <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (idx < len_n) begin
                        rd_address   <= CHECK_BASE + ADDR_W'(idx);
                        gold_address <= ADDR_W'(idx);
                        idx          <= idx + 1'b1;
                    end else begin
                        rd_enable <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    // Held until reset; a mismatch found in the DRAIN cycle
                    // still reports its single mis_valid pulse here.
                end
                default: state <= S_RUN;
            endcase

            // Word 0 is issued in the same edge the sweep is entered, so
            // the sweep takes exactly N cycles.
            if (start_now) begin
                len_n <= start_n;
                if (start_n == '0) begin
                    state     <= S_DONE;
                    done      <= 1'b1;
                    rd_enable <= 1'b0;
                end else begin
                    state        <= S_SWEEP;
                    rd_enable    <= 1'b1;
                    rd_address   <= CHECK_BASE;
                    gold_address <= '0;
                    idx          <= CNT_W'(1);
                end
            end
        end
    end

endmodule
